// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single data-memory port between instruction
// fetch (IF) and the Memory-stage load/store requester (LS). One access is
// outstanding at a time. Accesses that wait too long for i_d_valid are
// aborted and reported through o_err.
//
// Build option: define MEM_ARB_ROUND_ROBIN_EN to alternate grants under
// contention. When it is not defined, LS always wins contention.
module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  // fetch requester
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic              o_if_gnt,
  output logic              o_if_rvalid,
  output logic [DATA_W-1:0] o_if_rdata,
  // load/store requester
  input  logic              i_ls_req,
  input  logic              i_ls_wr_en,
  input  logic [3:0]        i_ls_sel,
  input  logic [ADDR_W-1:0] i_ls_addr,
  input  logic [DATA_W-1:0] i_ls_wdata,
  output logic              o_ls_gnt,
  output logic              o_ls_rvalid,
  output logic [DATA_W-1:0] o_ls_rdata,
  output logic              o_err,
  // memory port
  output logic              o_wr_en,
  output logic [3:0]        o_sel,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_addr_vld,
  output logic [DATA_W-1:0] o_wdata,
  input  logic [DATA_W-1:0] i_rdata,
  input  logic              i_d_valid,
  output logic              o_busy
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_IF_ACC = 2'd1;
  localparam logic [1:0] ST_LS_ACC = 2'd2;

  // Last-grant flag encoding.
  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_LS = 1'b1;

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  logic [1:0]        state_q,     state_d;
  logic [7:0]        wait_cnt_q,  wait_cnt_d;
  logic              last_gnt_q,  last_gnt_d;

  logic              wr_en_q,     wr_en_d;
  logic [3:0]        sel_q,       sel_d;
  logic [ADDR_W-1:0] addr_q,      addr_d;
  logic              addr_vld_q,  addr_vld_d;
  logic [DATA_W-1:0] wdata_q,     wdata_d;

  logic              if_rvalid_q, if_rvalid_d;
  logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
  logic              ls_rvalid_q, ls_rvalid_d;
  logic [DATA_W-1:0] ls_rdata_q,  ls_rdata_d;
  logic              err_q,       err_d;

  logic              in_idle;
  logic              pick_ls;
  logic              if_gnt;
  logic              ls_gnt;
  logic [7:0]        wait_cnt_inc;
  logic              timeout;

  assign in_idle = (state_q == ST_IDLE);

  // Arbitration: decide which requester wins when the port is idle.
`ifdef MEM_ARB_ROUND_ROBIN_EN
  always_comb begin
    pick_ls = i_ls_req && (!i_if_req || (last_gnt_q == GNT_IF));
  end
`else
  // Fixed priority keeps the flag for a future policy switch; it is not read.
  logic unused_last_gnt;
  assign unused_last_gnt = last_gnt_q;

  always_comb begin
    pick_ls = i_ls_req;
  end
`endif

  // Grants are only given in IDLE and are held off while reset is asserted
  // so every output reads 0 during reset.
  assign ls_gnt = in_idle && !rst && pick_ls;
  assign if_gnt = in_idle && !rst && i_if_req && !pick_ls;

  // Saturating wait counter increment and the abort condition it implies.
  assign wait_cnt_inc = (wait_cnt_q == 8'hFF) ? wait_cnt_q : (wait_cnt_q + 8'd1);
  assign timeout      = (wait_cnt_inc >= MAX_WAIT_C);

  // Next-state logic for the sequencer, command registers and responses.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    last_gnt_d  = last_gnt_q;
    wr_en_d     = wr_en_q;
    sel_d       = sel_q;
    addr_d      = addr_q;
    addr_vld_d  = addr_vld_q;
    wdata_d     = wdata_q;
    if_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    ls_rvalid_d = 1'b0;
    ls_rdata_d  = ls_rdata_q;
    err_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ls_gnt) begin
          // Load/store command passes through unmodified.
          wr_en_d    = i_ls_wr_en;
          sel_d      = i_ls_sel;
          addr_d     = i_ls_addr;
          wdata_d    = i_ls_wdata;
          addr_vld_d = 1'b1;
          wait_cnt_d = 8'd0;
          last_gnt_d = GNT_LS;
          state_d    = ST_LS_ACC;
        end else if (if_gnt) begin
          // Fetch is always a full-word read.
          wr_en_d    = 1'b0;
          sel_d      = 4'b1111;
          addr_d     = i_if_addr;
          wdata_d    = '0;
          addr_vld_d = 1'b1;
          wait_cnt_d = 8'd0;
          last_gnt_d = GNT_IF;
          state_d    = ST_IF_ACC;
        end
      end

      ST_IF_ACC, ST_LS_ACC: begin
        if (i_d_valid || timeout) begin
          // Completion takes precedence over an abort in the same cycle.
          if (state_q == ST_IF_ACC) begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = i_d_valid ? i_rdata : '0;
          end else begin
            ls_rvalid_d = 1'b1;
            ls_rdata_d  = (i_d_valid && !wr_en_q) ? i_rdata : '0;
          end
          err_d      = !i_d_valid;
          wr_en_d    = 1'b0;
          sel_d      = 4'b0000;
          addr_d     = '0;
          wdata_d    = '0;
          addr_vld_d = 1'b0;
          state_d    = ST_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_inc;
        end
      end

      default: begin
        wr_en_d    = 1'b0;
        sel_d      = 4'b0000;
        addr_d     = '0;
        wdata_d    = '0;
        addr_vld_d = 1'b0;
        state_d    = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any access in flight silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wait_cnt_q  <= 8'd0;
      last_gnt_q  <= GNT_IF;
      wr_en_q     <= 1'b0;
      sel_q       <= 4'b0000;
      addr_q      <= '0;
      addr_vld_q  <= 1'b0;
      wdata_q     <= '0;
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      ls_rvalid_q <= 1'b0;
      ls_rdata_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      last_gnt_q  <= last_gnt_d;
      wr_en_q     <= wr_en_d;
      sel_q       <= sel_d;
      addr_q      <= addr_d;
      addr_vld_q  <= addr_vld_d;
      wdata_q     <= wdata_d;
      if_rvalid_q <= if_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      ls_rvalid_q <= ls_rvalid_d;
      ls_rdata_q  <= ls_rdata_d;
      err_q       <= err_d;
    end
  end

  assign o_if_gnt    = if_gnt;
  assign o_ls_gnt    = ls_gnt;
  assign o_if_rvalid = if_rvalid_q;
  assign o_if_rdata  = if_rdata_q;
  assign o_ls_rvalid = ls_rvalid_q;
  assign o_ls_rdata  = ls_rdata_q;
  assign o_err       = err_q;
  assign o_wr_en     = wr_en_q;
  assign o_sel       = sel_q;
  assign o_addr      = addr_q;
  assign o_addr_vld  = addr_vld_q;
  assign o_wdata     = wdata_q;
  assign o_busy      = !in_idle;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter, built with MAX_WAIT = 4 so the
// timeout path is reached quickly. Inputs change on the falling edge and
// outputs are sampled there too, away from the active rising edge.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_if_req;
  logic [AW-1:0] i_if_addr;
  logic          o_if_gnt;
  logic          o_if_rvalid;
  logic [DW-1:0] o_if_rdata;
  logic          i_ls_req;
  logic          i_ls_wr_en;
  logic [3:0]    i_ls_sel;
  logic [AW-1:0] i_ls_addr;
  logic [DW-1:0] i_ls_wdata;
  logic          o_ls_gnt;
  logic          o_ls_rvalid;
  logic [DW-1:0] o_ls_rdata;
  logic          o_err;
  logic          o_wr_en;
  logic [3:0]    o_sel;
  logic [AW-1:0] o_addr;
  logic          o_addr_vld;
  logic [DW-1:0] o_wdata;
  logic [DW-1:0] i_rdata;
  logic          i_d_valid;
  logic          o_busy;

  int tests_run    = 0;
  int tests_failed = 0;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr), .o_if_gnt(o_if_gnt),
    .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata),
    .i_ls_req(i_ls_req), .i_ls_wr_en(i_ls_wr_en), .i_ls_sel(i_ls_sel),
    .i_ls_addr(i_ls_addr), .i_ls_wdata(i_ls_wdata), .o_ls_gnt(o_ls_gnt),
    .o_ls_rvalid(o_ls_rvalid), .o_ls_rdata(o_ls_rdata), .o_err(o_err),
    .o_wr_en(o_wr_en), .o_sel(o_sel), .o_addr(o_addr), .o_addr_vld(o_addr_vld),
    .o_wdata(o_wdata), .i_rdata(i_rdata), .i_d_valid(i_d_valid), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One load/store: grant at T, i_d_valid pulsed at T+dv_at (0 = never).
  // Returns the cycle offset of the first o_ls_rvalid (-1 if none) and the
  // o_err / o_ls_rdata seen with it.
  task automatic run_ls(input string tag, input logic wr, input logic [3:0] sel,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int dv_at, input logic [31:0] rd,
                        output int rv_at, output logic err_at, output logic [31:0] data_at);
    rv_at   = -1;
    err_at  = 1'b0;
    data_at = 32'h0;
    @(negedge clk);
    i_ls_wr_en = wr; i_ls_sel = sel; i_ls_addr = addr; i_ls_wdata = wdata;
    i_ls_req   = 1'b1;
    #1;
    check_value({tag, "_ls_gnt"}, 32'(o_ls_gnt), 32'd1);
    check_value({tag, "_if_gnt"}, 32'(o_if_gnt), 32'd0);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      i_ls_req = 1'b0;
      if (c == 1) begin
        check_value({tag, "_wr_en"},    32'(o_wr_en),    32'(wr));
        check_value({tag, "_sel"},      32'(o_sel),      32'(sel));
        check_value({tag, "_addr"},     o_addr,          addr);
        check_value({tag, "_wdata"},    o_wdata,         wdata);
        check_value({tag, "_addr_vld"}, 32'(o_addr_vld), 32'd1);
      end
      if (o_ls_rvalid && rv_at < 0) begin
        rv_at   = c;
        err_at  = o_err;
        data_at = o_ls_rdata;
        check_value({tag, "_busy_at_rvalid"},     32'(o_busy),     32'd0);
        check_value({tag, "_addr_vld_at_rvalid"}, 32'(o_addr_vld), 32'd0);
      end
      i_d_valid = (c == dv_at);
      i_rdata   = rd;
    end
    i_d_valid = 1'b0;
    $display("[TB] %s: addr=0x%08h wr=%0d rvalid at T+%0d err=%0d rdata=0x%08h",
             tag, addr, wr, rv_at, err_at, data_at);
  endtask

  // One fetch with memory answering at T+1.
  task automatic run_if(input string tag, input logic [31:0] addr, input logic [31:0] rd);
    @(negedge clk);
    i_if_req = 1'b1; i_if_addr = addr;
    #1;
    check_value({tag, "_if_gnt"}, 32'(o_if_gnt), 32'd1);
    @(negedge clk);
    i_if_req = 1'b0;
    check_value({tag, "_addr_vld"}, 32'(o_addr_vld), 32'd1);
    check_value({tag, "_sel"},      32'(o_sel),      32'hF);
    check_value({tag, "_wr_en"},    32'(o_wr_en),    32'd0);
    check_value({tag, "_addr"},     o_addr,          addr);
    check_value({tag, "_busy"},     32'(o_busy),     32'd1);
    i_d_valid = 1'b1; i_rdata = rd;
    @(negedge clk);
    i_d_valid = 1'b0;
    check_value({tag, "_rvalid"}, 32'(o_if_rvalid), 32'd1);
    check_value({tag, "_rdata"},  o_if_rdata,       rd);
    check_value({tag, "_err"},    32'(o_err),       32'd0);
    check_value({tag, "_busy_T2"}, 32'(o_busy),     32'd0);
    check_value({tag, "_ls_rvalid"}, 32'(o_ls_rvalid), 32'd0);
    @(negedge clk);
    check_value({tag, "_rvalid_pulse"}, 32'(o_if_rvalid), 32'd0);
    check_value({tag, "_rdata_hold"},   o_if_rdata,       rd);
    $display("[TB] %s: addr=0x%08h rdata=0x%08h", tag, addr, o_if_rdata);
  endtask

  int          rv;
  logic        er;
  logic [31:0] dat;
  logic        seen_rvalid;
  int          n_gnt;
  int          both_gnt;
  logic [3:0]  gnt_ls_seq;
  logic [3:0]  exp_seq;

  initial begin
    rst = 1'b1;
    i_if_req = 0; i_if_addr = '0; i_ls_req = 0; i_ls_wr_en = 0; i_ls_sel = '0;
    i_ls_addr = '0; i_ls_wdata = '0; i_rdata = '0; i_d_valid = 0;

    // Reset state.
    @(negedge clk);
    check_value("rst_addr_vld", 32'(o_addr_vld), 32'd0);
    check_value("rst_busy",     32'(o_busy),     32'd0);
    check_value("rst_sel",      32'(o_sel),      32'd0);
    check_value("rst_rvalids",  32'({o_if_rvalid, o_ls_rvalid, o_err}), 32'd0);
    check_value("rst_rdata",    o_if_rdata | o_ls_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Fetch only.
    run_if("fetch", 32'h0000_0100, 32'hDEAD_BEEF);

    // Store with three wait cycles: memory data must not leak into rdata.
    run_ls("store", 1'b1, 4'b0011, 32'h0000_0204, 32'h0000_1234, 4, 32'hCAFE_F00D, rv, er, dat);
    check_value("store_rv_cycle", 32'(rv), 32'd5);
    check_value("store_err",      32'(er), 32'd0);
    check_value("store_rdata",    dat,     32'd0);

    // Load completing in the same cycle the abort would fire.
    run_ls("load_t4", 1'b0, 4'b1111, 32'h0000_0208, 32'h0, 4, 32'h55AA_1234, rv, er, dat);
    check_value("load_t4_rv_cycle", 32'(rv), 32'd5);
    check_value("load_t4_err",      32'(er), 32'd0);
    check_value("load_t4_rdata",    dat,     32'h55AA_1234);

    // Load that never completes: aborted at T+MAX_WAIT+1.
    run_ls("timeout", 1'b0, 4'b1111, 32'h0000_0300, 32'h0, 0, 32'h9999_9999, rv, er, dat);
    check_value("timeout_rv_cycle", 32'(rv), 32'(MW + 1));
    check_value("timeout_err",      32'(er), 32'd1);
    check_value("timeout_rdata",    dat,     32'd0);
    check_value("err_idle",         32'(o_err), 32'd0);

    // Reset in the middle of a pending load.
    @(negedge clk);
    i_ls_wr_en = 0; i_ls_sel = 4'hF; i_ls_addr = 32'h400; i_ls_req = 1'b1;
    #1;
    check_value("rstacc_gnt", 32'(o_ls_gnt), 32'd1);
    @(negedge clk);
    i_ls_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_value("rstacc_addr_vld", 32'(o_addr_vld), 32'd0);
    check_value("rstacc_busy",     32'(o_busy),     32'd0);
    check_value("rstacc_cmd",      o_addr | 32'(o_sel) | 32'(o_wr_en), 32'd0);
    check_value("rstacc_rdata",    o_ls_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    // Stray i_d_valid while idle must be ignored.
    seen_rvalid = 1'b0;
    i_d_valid = 1'b1; i_rdata = 32'h7777_7777;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      seen_rvalid = seen_rvalid | o_ls_rvalid | o_if_rvalid | o_err | o_busy;
    end
    i_d_valid = 1'b0;
    check_value("stray_dvalid_quiet", 32'(seen_rvalid), 32'd0);
    check_value("stray_ls_rdata",     o_ls_rdata,       32'd0);
    $display("[TB] reset mid-access and stray i_d_valid: quiet=%0d", !seen_rvalid);
    run_if("fetch_after_rst", 32'h0000_0500, 32'h1111_2222);

    // Contention: both requesters hold their request, memory always ready.
    @(negedge clk);
    i_ls_wr_en = 0; i_ls_sel = 4'hF; i_ls_addr = 32'h600;
    i_if_addr = 32'h700;
    i_ls_req = 1'b1; i_if_req = 1'b1; i_d_valid = 1'b1; i_rdata = 32'h0;
    n_gnt = 0; both_gnt = 0; gnt_ls_seq = '0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (o_ls_gnt && o_if_gnt) both_gnt++;
      if ((o_ls_gnt || o_if_gnt) && n_gnt < 4) begin
        gnt_ls_seq[n_gnt] = o_ls_gnt;
        n_gnt++;
      end
      @(negedge clk);
    end
    i_ls_req = 1'b0; i_if_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    i_d_valid = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_seq = 4'b0101;  // bit0 first: LS, IF, LS, IF
`else
    exp_seq = 4'b1111;  // LS every time
`endif
    check_value("contention_n_gnt", 32'(n_gnt),      32'd4);
    check_value("contention_both",  32'(both_gnt),   32'd0);
    check_value("contention_order", 32'(gnt_ls_seq), 32'(exp_seq));
    $display("[TB] contention: grants (bit0 first, 1=LS) = %b", gnt_ls_seq);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
